// File: rtl/sa_pkg.sv
// Shared systolic-array definitions: accumulator FSM encodings and the default
// product/accumulator widths used by the PE and array top.
package sa_pkg;

    localparam int SA_WIDTH_MUL = 32;
    localparam int SA_WIDTH_ACC = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: one guard bit above WIDTH exposes overflow,
// which then selects the clamp value instead of the wrapped sum.
module sat_add #(
    parameter int WIDTH  = 40,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH:0] raw;

    always_comb begin
        raw = '0;
        sum = '0;
        ovf = 1'b0;
        if (SIGNED != 0) begin
            raw = {a[WIDTH-1], a} + {b[WIDTH-1], b};
            sum = raw[WIDTH-1:0];
            // guard and MSB disagree only when the true result left the range;
            // the guard bit carries the true sign and picks the clamp direction
            if (raw[WIDTH] != raw[WIDTH-1]) begin
                ovf = 1'b1;
                sum = raw[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end
        end else begin
            raw = {1'b0, a} + {1'b0, b};
            sum = raw[WIDTH-1:0];
            if (raw[WIDTH]) begin
                ovf = 1'b1;
                sum = '1;
            end
        end
    end

endmodule

// File: rtl/mul_accumulator.sv
// Dot-product accumulator behind the log multiplier: sums DEPTH_K products (or up
// to an early in_last) with saturation and holds the result on a valid/ready port.
module mul_accumulator
    import sa_pkg::*;
#(
    parameter int WIDTH_MUL = SA_WIDTH_MUL,
    parameter int WIDTH_ACC = SA_WIDTH_ACC,
    parameter int DEPTH_K   = 16,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [WIDTH_MUL-1:0] prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_ACC-1:0] acc_out,
    output logic                 ovf
);

    localparam int CNT_W = $clog2(DEPTH_K + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH_K - 1);

    acc_state_e           state_q, state_d;
    logic [WIDTH_ACC-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH_ACC-1:0] prod_ext;
    logic [WIDTH_ACC-1:0] add_base;
    logic [WIDTH_ACC-1:0] add_sum;
    logic                 add_ovf;
    logic                 accept;
    logic                 ext_bit;

    assign ext_bit = (SIGNED != 0) ? prod[WIDTH_MUL-1] : 1'b0;

    generate
        if (WIDTH_ACC > WIDTH_MUL) begin : g_ext
            assign prod_ext = {{(WIDTH_ACC-WIDTH_MUL){ext_bit}}, prod};
        end else begin : g_noext
            assign prod_ext = prod;
        end
    endgenerate

    // a fresh result never picks up a stale sum, whatever acc_q holds
    assign add_base = (state_q == ST_IDLE) ? '0 : acc_q;

    sat_add #(
        .WIDTH  (WIDTH_ACC),
        .SIGNED (SIGNED)
    ) u_sat_add (
        .a   (add_base),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid & in_ready;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        acc_d = add_sum;
                        ovf_d = ((state_q == ST_IDLE) ? 1'b0 : ovf_q) | add_ovf;
                        if (cnt_q == CNT_LAST || in_last) begin
                            state_d = ST_HOLD;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ACC;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mul_accumulator.sv
// Four accumulator configurations driven by directed and random traffic, each
// checked every cycle against a saturating-integer model of the result stream.
module tb_mul_accumulator;

    localparam int WM [4] = '{32, 8, 8, 32};
    localparam int WA [4] = '{40, 8, 8, 40};
    localparam int KK [4] = '{4, 4, 2, 16};
    localparam int SG [4] = '{0, 0, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr       [4];
    logic        in_valid  [4];
    logic        in_last   [4];
    logic        out_ready [4];
    logic [31:0] prod      [4];
    logic        out_valid [4];
    logic        in_ready  [4];
    logic        ovf_o     [4];
    logic [63:0] acc_o     [4];
    logic [39:0] acc0, acc3;
    logic [7:0]  acc1, acc2;

    longint m_sum  [4];
    int     m_cnt  [4];
    bit     m_hold [4];
    bit     m_ovf  [4];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign acc_o[0] = {24'd0, acc0};
    assign acc_o[1] = {56'd0, acc1};
    assign acc_o[2] = {56'd0, acc2};
    assign acc_o[3] = {24'd0, acc3};

    mul_accumulator #(.WIDTH_MUL(32), .WIDTH_ACC(40), .DEPTH_K(4), .SIGNED(0)) u_k4 (
        .clk(clk), .rst(rst), .clr(clr[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_last(in_last[0]), .prod(prod[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .acc_out(acc0), .ovf(ovf_o[0]));

    mul_accumulator #(.WIDTH_MUL(8), .WIDTH_ACC(8), .DEPTH_K(4), .SIGNED(0)) u_u8 (
        .clk(clk), .rst(rst), .clr(clr[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_last(in_last[1]), .prod(prod[1][7:0]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .acc_out(acc1), .ovf(ovf_o[1]));

    mul_accumulator #(.WIDTH_MUL(8), .WIDTH_ACC(8), .DEPTH_K(2), .SIGNED(1)) u_s8 (
        .clk(clk), .rst(rst), .clr(clr[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_last(in_last[2]), .prod(prod[2][7:0]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .acc_out(acc2), .ovf(ovf_o[2]));

    mul_accumulator #(.WIDTH_MUL(32), .WIDTH_ACC(40), .DEPTH_K(16), .SIGNED(0)) u_k16 (
        .clk(clk), .rst(rst), .clr(clr[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_last(in_last[3]), .prod(prod[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .acc_out(acc3), .ovf(ovf_o[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // result-level model: exact integer sum clamped to the representable range
    task automatic model_step();
        for (int i = 0; i < 4; i++) begin
            longint p, lo, hi, s;
            if (clr[i]) begin
                m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_ovf[i] = 0;
            end else if (m_hold[i]) begin
                if (out_ready[i]) begin
                    m_hold[i] = 0; m_sum[i] = 0; m_ovf[i] = 0;
                end
            end else if (in_valid[i]) begin
                p = longint'(prod[i]) & ((64'sd1 << WM[i]) - 1);
                if (SG[i] != 0 && p[WM[i]-1]) p = p - (64'sd1 << WM[i]);
                if (SG[i] != 0) begin
                    lo = -(64'sd1 << (WA[i] - 1));
                    hi = (64'sd1 << (WA[i] - 1)) - 1;
                end else begin
                    lo = 0;
                    hi = (64'sd1 << WA[i]) - 1;
                end
                s = m_sum[i] + p;
                if (s > hi) begin s = hi; m_ovf[i] = 1; end
                else if (s < lo) begin s = lo; m_ovf[i] = 1; end
                m_sum[i] = s;
                m_cnt[i]++;
                if (m_cnt[i] == KK[i] || in_last[i]) begin
                    m_hold[i] = 1;
                    m_cnt[i]  = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovld%0d", i), 64'(out_valid[i]), 64'(m_hold[i]));
            chk($sformatf("irdy%0d", i), 64'(in_ready[i]), 64'(!m_hold[i]));
            if (m_hold[i]) begin
                chk($sformatf("acc%0d", i), acc_o[i], 64'(m_sum[i]) & ((64'd1 << WA[i]) - 1));
                chk($sformatf("ovf%0d", i), 64'(ovf_o[i]), 64'(m_ovf[i]));
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic put(input int i, input logic [31:0] p, input bit last);
        in_valid[i] = 1'b1;
        prod[i]     = p;
        in_last[i]  = last;
        tick();
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            clr[i] = 0; in_valid[i] = 0; in_last[i] = 0; out_ready[i] = 1; prod[i] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_acc%0d", i), acc_o[i], 64'd0);
            chk($sformatf("rst_ovf%0d", i), 64'(ovf_o[i]), 64'd0);
            chk($sformatf("rst_vld%0d", i), 64'(out_valid[i]), 64'd0);
            chk($sformatf("rst_rdy%0d", i), 64'(in_ready[i]), 64'd1);
        end
        tick();

        // back-to-back K=4 with a ready consumer
        put(0, 1, 0); put(0, 2, 0); put(0, 3, 0); put(0, 4, 0);
        chk("t1_vld", 64'(out_valid[0]), 64'd1);
        chk("t1_acc", acc_o[0], 64'd10);
        chk("t1_ovf", 64'(ovf_o[0]), 64'd0);
        tick();
        chk("t1_rdy", 64'(in_ready[0]), 64'd1);

        // backpressure: held result, products refused
        out_ready[0] = 0;
        put(0, 1, 0); put(0, 2, 0); put(0, 3, 0); put(0, 4, 0);
        in_valid[0] = 1; prod[0] = 99;
        repeat (5) begin
            tick();
            chk("t2_acc", acc_o[0], 64'd10);
            chk("t2_rdy", 64'(in_ready[0]), 64'd0);
        end
        in_valid[0] = 0; out_ready[0] = 1;
        tick();
        chk("t2_drop", 64'(out_valid[0]), 64'd0);
        put(0, 2, 0); put(0, 2, 0); put(0, 2, 0); put(0, 2, 0);
        chk("t2_next", acc_o[0], 64'd8);
        tick();

        // saturation, unsigned then signed
        out_ready[1] = 0;
        put(1, 200, 0); put(1, 100, 1);
        chk("t3_uacc", acc_o[1], 64'd255);
        chk("t3_uovf", 64'(ovf_o[1]), 64'd1);
        out_ready[1] = 1; tick();
        out_ready[2] = 0;
        put(2, 32'h9C, 0); put(2, 32'h9C, 0);
        chk("t3_sacc", acc_o[2], 64'h80);
        chk("t3_sovf", 64'(ovf_o[2]), 64'd1);
        out_ready[2] = 1; tick();
        out_ready[2] = 0;
        put(2, 1, 0); put(2, 2, 0);
        chk("t3_nacc", acc_o[2], 64'd3);
        chk("t3_novf", 64'(ovf_o[2]), 64'd0);
        out_ready[2] = 1; tick();

        // early end then a full K=16 run proves the count restarted
        out_ready[3] = 0;
        put(3, 5, 0); put(3, 7, 1);
        chk("t4_acc", acc_o[3], 64'd12);
        out_ready[3] = 1; tick();
        out_ready[3] = 0;
        repeat (15) put(3, 1, 0);
        chk("t4_nvld", 64'(out_valid[3]), 64'd0);
        put(3, 1, 0);
        chk("t4_vld", 64'(out_valid[3]), 64'd1);
        chk("t4_acc16", acc_o[3], 64'd16);
        out_ready[3] = 1; tick();

        // clr discards partial sum and a held result
        out_ready[0] = 0;
        put(0, 1, 0); put(0, 1, 0); put(0, 1, 0);
        clr[0] = 1; in_valid[0] = 1; prod[0] = 9;
        tick();
        clr[0] = 0; in_valid[0] = 0;
        put(0, 1, 0); put(0, 1, 0); put(0, 1, 0); put(0, 1, 0);
        chk("t5_acc", acc_o[0], 64'd4);
        clr[0] = 1; tick(); clr[0] = 0;
        chk("t5_clr", 64'(out_valid[0]), 64'd0);
        out_ready[0] = 1;

        // async reset between edges
        put(0, 7, 0); put(0, 7, 0);
        out_ready[1] = 0; put(1, 3, 1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t6_acc%0d", i), acc_o[i], 64'd0);
            chk($sformatf("t6_vld%0d", i), 64'(out_valid[i]), 64'd0);
            chk($sformatf("t6_ovf%0d", i), 64'(ovf_o[i]), 64'd0);
        end
        model_reset();
        out_ready[1] = 1;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // random traffic on all four configurations
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                clr[i]       = ($urandom % 40) == 0;
                in_valid[i]  = ($urandom % 4) != 0;
                in_last[i]   = ($urandom % 8) == 0;
                out_ready[i] = ($urandom % 3) != 0;
                prod[i]      = ($urandom % 2) ? $urandom : ($urandom % 16);
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
